oam_dma_ctrl: RTL

- Sprite (SPR-RAM) DMA engine between the CPU bus and the memory/IO map.
- When the CPU writes page P to 4014h, the block halts the CPU and copies bytes P00h-PFFh to the SPR-RAM data register at 2004h, one byte per read/write cycle pair.
- When idle it passes the CPU bus through to memory unchanged.
- During DMA it owns the memory bus.

---
 rtl/oam_dma_if.sv | 29 ++
 rtl/oam_dma_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/oam_dma_if.sv
// CPU-side and memory-side bus bundle for the sprite DMA engine.
// slave: the DMA controller; master: the CPU/memory environment driving it.
interface oam_dma_if;
  logic [15:0] cpu_addr_out;
  logic [7:0]  cpu_data_out;
  logic        cpu_wen;
  logic        cpu_ren;
  logic [7:0]  cpu_data_in;
  logic        cpu_rdy;
  logic [15:0] mem_addr_out;
  logic [7:0]  mem_data_out;
  logic        mem_wen;
  logic        mem_ren;
  logic [7:0]  mem_data_in;
  logic        dma_busy;
  logic        dma_done;

  modport slave (
    input  cpu_addr_out, cpu_data_out, cpu_wen, cpu_ren, mem_data_in,
    output cpu_data_in, cpu_rdy, mem_addr_out, mem_data_out, mem_wen, mem_ren,
           dma_busy, dma_done
  );

  modport master (
    output cpu_addr_out, cpu_data_out, cpu_wen, cpu_ren, mem_data_in,
    input  cpu_data_in, cpu_rdy, mem_addr_out, mem_data_out, mem_wen, mem_ren,
           dma_busy, dma_done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: a CPU write of page P to DMA_REG_ADDR halts the CPU and copies P00-PFF to OAM_DATA_ADDR.
// Optional macro OAM_DMA_ALIGN_EN inserts an ALIGN cycle when HALT falls on an odd cycle.
//
// state | meaning
// IDLE  | CPU bus passed straight through to memory
// HALT  | dummy cycle after the trigger write, no access
// ALIGN | extra dummy cycle when HALT was odd (OAM_DMA_ALIGN_EN only)
// RD    | read source byte {page,idx} into data_q
// WR    | write data_q to OAM_DATA_ADDR, advance idx
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic      clk,
  input  logic      rst,
  oam_dma_if.slave  bus
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, RD, WR} state_t;
  logic parity;
`else
  typedef enum logic [1:0] {IDLE, HALT, RD, WR} state_t;
`endif

  state_t     state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data_q;
  logic       done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      page   <= 8'h00;
      idx    <= 8'h00;
      data_q <= 8'h00;
      done_q <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
      parity <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
      parity <= ~parity;
`endif
      case (state)
        IDLE: begin
          if (bus.cpu_wen && bus.cpu_addr_out == DMA_REG_ADDR) begin
            page  <= bus.cpu_data_out;
            idx   <= 8'h00;
            state <= HALT;
          end
        end
`ifdef OAM_DMA_ALIGN_EN
        HALT:  state <= parity ? ALIGN : RD;
        ALIGN: state <= RD;
`else
        HALT:  state <= RD;
`endif
        RD: begin
          data_q <= bus.mem_data_in;
          state  <= WR;
        end
        WR: begin
          // idx wraps only after the last write; the source never leaves the page
          idx <= idx + 8'h01;
          if (idx == LAST_IDX) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            state <= RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dma_done = done_q;

  always_comb begin
    bus.mem_addr_out = 16'h0000;
    bus.mem_data_out = 8'h00;
    bus.mem_wen      = 1'b0;
    bus.mem_ren      = 1'b0;
    bus.cpu_data_in  = 8'h00;
    bus.cpu_rdy      = 1'b0;
    bus.dma_busy     = 1'b1;
    if (rst) begin
      bus.cpu_rdy  = 1'b1;
      bus.dma_busy = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.mem_addr_out = bus.cpu_addr_out;
          bus.mem_data_out = bus.cpu_data_out;
          bus.mem_wen      = bus.cpu_wen;
          bus.mem_ren      = bus.cpu_ren;
          bus.cpu_data_in  = bus.mem_data_in;
          bus.cpu_rdy      = 1'b1;
          bus.dma_busy     = 1'b0;
        end
        RD: begin
          bus.mem_ren      = 1'b1;
          bus.mem_addr_out = {page, idx};
        end
        WR: begin
          bus.mem_wen      = 1'b1;
          bus.mem_addr_out = OAM_DATA_ADDR;
          bus.mem_data_out = data_q;
        end
        default: ;
      endcase
    end
  end

endmodule
